// File: rtl/fuzzy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_pkg
// Brief    : Shared widths, default sweep constants, FSM states and input clamp
// Revision : 1.0
// ============================================================================
package fuzzy_pkg;

    localparam int IN_W         = 8;
    localparam int RAW_W        = 9;
    localparam int IDX_W        = 9;
    localparam int DEF_STEP     = 16;
    localparam int DEF_GRID_MAX = 256;
    localparam int DEF_MIN_IN   = 1;
    localparam int DEF_MAX_IN   = 254;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STALL   = 3'd4,
        ST_DONE    = 3'd5
    } sweep_state_t;

    // Compare at full raw width so 256 saturates instead of wrapping to 0
    function automatic logic [IN_W-1:0] clamp_in(
        input logic [RAW_W-1:0] raw,
        input logic [RAW_W-1:0] lo,
        input logic [RAW_W-1:0] hi
    );
        logic [RAW_W-1:0] v;
        if (raw < lo)
            v = lo;
        else if (raw > hi)
            v = hi;
        else
            v = raw;
        return IN_W'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fuzzy_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_result_fifo
// Brief    : Registered result FIFO, no fall-through; head reads as 0 when empty
// Revision : 1.0
// ============================================================================
module fuzzy_result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fuzzy_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_sweep_sequencer
// Brief    : Grid sweep of Fuzzy_1 inputs with settle window and result capture
// Revision : 1.0
// ============================================================================
module fuzzy_sweep_sequencer
    import fuzzy_pkg::*;
#(
    parameter int STEP       = DEF_STEP,
    parameter int GRID_MAX   = DEF_GRID_MAX,
    parameter int MIN_IN     = DEF_MIN_IN,
    parameter int MAX_IN     = DEF_MAX_IN,
    parameter int SETTLE_CYC = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk_0,
    input  logic             Srst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  Entrada_01,
    output logic [IN_W-1:0]  Entrada_02,
    output logic             EN_REGRAS,
    input  logic [IN_W-1:0]  saida_defuzzy,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IN_W-1:0]  res_data,
    output logic [IDX_W-1:0] res_idx
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] c_settle_load = SET_W'(SETTLE_CYC - 1);
    localparam logic [RAW_W:0]   c_step        = (RAW_W + 1)'(STEP);
    localparam logic [RAW_W:0]   c_grid        = (RAW_W + 1)'(GRID_MAX);
    localparam logic [RAW_W-1:0] c_min         = RAW_W'(MIN_IN);
    localparam logic [RAW_W-1:0] c_max         = RAW_W'(MAX_IN);
    localparam logic [IN_W-1:0]  c_min_in      = IN_W'(MIN_IN);

    sweep_state_t          r_state;
    sweep_state_t          w_state_next;
    logic [RAW_W-1:0]      r_raw_i;
    logic [RAW_W-1:0]      r_raw_j;
    logic [IDX_W-1:0]      r_idx;
    logic [SET_W-1:0]      r_settle;
    logic [IN_W-1:0]       r_in1;
    logic [IN_W-1:0]       r_in2;
    logic [RAW_W:0]        w_i_sum;
    logic [RAW_W:0]        w_j_sum;
    logic                  w_i_wrap;
    logic                  w_j_wrap;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_can_push;
    logic                  w_full;
    logic                  w_empty;
    logic [IDX_W+IN_W-1:0] w_head;

    // One extra bit keeps raw+STEP from wrapping before the range test
    assign w_i_sum  = {1'b0, r_raw_i} + c_step;
    assign w_j_sum  = {1'b0, r_raw_j} + c_step;
    assign w_i_wrap = (w_i_sum > c_grid);
    assign w_j_wrap = (w_j_sum > c_grid);
    assign w_last   = w_i_wrap && w_j_wrap;

    assign res_valid  = !w_empty;
    assign w_pop      = res_valid && res_ready;
    assign w_can_push = !w_full || w_pop;

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_next = ST_APPLY;
            end
            ST_APPLY: begin
                w_state_next = abort ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)
                    w_state_next = ST_IDLE;
                else if (r_settle == '0)
                    w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE, ST_STALL: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_can_push) begin
                    w_push       = 1'b1;
                    w_state_next = w_last ? ST_DONE : ST_APPLY;
                end else begin
                    w_state_next = ST_STALL;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            r_raw_i  <= '0;
            r_raw_j  <= '0;
            r_idx    <= '0;
            r_settle <= '0;
            r_in1    <= c_min_in;
            r_in2    <= c_min_in;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_raw_i <= '0;
                r_raw_j <= '0;
                r_idx   <= '0;
            end
            if (r_state == ST_APPLY) begin
                r_in1    <= clamp_in(r_raw_i, c_min, c_max);
                r_in2    <= clamp_in(r_raw_j, c_min, c_max);
                r_settle <= c_settle_load;
            end else if (r_state == ST_SETTLE && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
            if (w_push) begin
                if (w_j_wrap) begin
                    r_raw_j <= '0;
                    r_raw_i <= w_i_sum[RAW_W-1:0];
                end else begin
                    r_raw_j <= w_j_sum[RAW_W-1:0];
                end
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    fuzzy_result_fifo #(
        .WIDTH (IDX_W + IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk_0),
        .rst     (Srst),
        .i_push  (w_push),
        .i_data  ({r_idx, saida_defuzzy}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign Entrada_01 = r_in1;
    assign Entrada_02 = r_in2;
    assign busy       = (r_state != ST_IDLE);
    assign EN_REGRAS  = busy;
    assign done       = (r_state == ST_DONE);
    assign res_idx    = w_head[IDX_W+IN_W-1:IN_W];
    assign res_data   = w_head[IN_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fuzzy_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fuzzy_sweep_sequencer
// Brief    : Self-checking bench: point table, scoreboard on popped results,
//            backpressure, abort and asynchronous reset sequences
// Revision : 1.0
// ============================================================================
module tb_fuzzy_sweep_sequencer;

    localparam int SETTLE = 33;
    localparam int PER_PT = SETTLE + 2;
    localparam int NPTS   = 289;
    localparam int NSIDE  = 17;

    logic       clk_0 = 1'b0;
    logic       Srst;
    logic       start;
    logic       abort;
    logic       res_ready;
    logic [7:0] Entrada_01;
    logic [7:0] Entrada_02;
    logic [7:0] saida_defuzzy;
    logic [7:0] res_data;
    logic [8:0] res_idx;
    logic       EN_REGRAS;
    logic       busy;
    logic       done;
    logic       res_valid;

    int checks   = 0;
    int failures = 0;
    int m        = 0;
    int done_cnt = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 follow man_ready
    int man_ready  = 0;
    int epoch      = 0;
    int exp_idx    = 0;
    int seen_epoch = 0;

    always #5 clk_0 = ~clk_0;

    fuzzy_sweep_sequencer dut (
        .clk_0         (clk_0),
        .Srst          (Srst),
        .start         (start),
        .abort         (abort),
        .Entrada_01    (Entrada_01),
        .Entrada_02    (Entrada_02),
        .EN_REGRAS     (EN_REGRAS),
        .saida_defuzzy (saida_defuzzy),
        .busy          (busy),
        .done          (done),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_idx       (res_idx)
    );

    // Fuzzy_1 stand-in: XOR surface that only becomes visible SETTLE edges
    // after the inputs change, so an early capture reads the previous point
    logic [7:0] fz_pipe [SETTLE];
    always @(posedge clk_0) begin
        fz_pipe[0] <= Entrada_01 ^ Entrada_02;
        for (int p = 1; p < SETTLE; p++)
            fz_pipe[p] <= fz_pipe[p-1];
    end
    assign saida_defuzzy = fz_pipe[SETTLE-1];

    function automatic int clamp_ref(input int r);
        if (r < 1)   return 1;
        if (r > 254) return 254;
        return r;
    endfunction

    function automatic int pt_e1(input int k);
        return clamp_ref((k / NSIDE) * 16);
    endfunction

    function automatic int pt_e2(input int k);
        return clamp_ref((k % NSIDE) * 16);
    endfunction

    function automatic int exp_data(input int k);
        return pt_e1(k) ^ pt_e2(k);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer + scoreboard: every pop must be the next point of the sweep
    always begin
        @(negedge clk_0);
        #1;
        if (seen_epoch != epoch) begin
            seen_epoch = epoch;
            exp_idx    = 0;
        end
        if (ready_mode == 0)
            res_ready = 1'b1;
        else if (ready_mode == 1)
            res_ready = ($urandom_range(0, 3) != 0);
        else
            res_ready = (man_ready != 0);
        if (!Srst && res_valid && res_ready) begin
            chk("pop_idx", int'(res_idx), exp_idx);
            chk("pop_data", int'(res_data), exp_data(exp_idx));
            exp_idx++;
        end
    end

    always begin
        @(negedge clk_0);
        #2;
        if (done === 1'b1)
            done_cnt++;
    end

    task automatic advance_to(input int t);
        while (m < t) begin
            @(negedge clk_0);
            m++;
        end
    endtask

    task automatic start_sweep();
        start = 1'b1;
        @(negedge clk_0);
        start = 1'b0;
        m = 0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk_0);
            n++;
        end
        chk("done_within_bound", int'(done === 1'b1), 1);
        @(negedge clk_0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (res_valid !== 1'b0 && n < bound) begin
            @(negedge clk_0);
            n++;
        end
        chk("drain_empty", int'(res_valid), 0);
        @(negedge clk_0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_e1"},    int'(Entrada_01), 1);
        chk({tag, "_e2"},    int'(Entrada_02), 1);
        chk({tag, "_en"},    int'(EN_REGRAS), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_data"},  int'(res_data), 0);
        chk({tag, "_idx"},   int'(res_idx), 0);
    endtask

    typedef struct {
        int k;
        int e1;
        int e2;
    } pt_vec_t;

    pt_vec_t vec [12];
    int      d0;

    initial begin
        vec[0]  = '{0,   1,   1};
        vec[1]  = '{1,   1,   16};
        vec[2]  = '{2,   1,   32};
        vec[3]  = '{15,  1,   240};
        vec[4]  = '{16,  1,   254};
        vec[5]  = '{17,  16,  1};
        vec[6]  = '{18,  16,  16};
        vec[7]  = '{33,  16,  254};
        vec[8]  = '{271, 240, 254};
        vec[9]  = '{272, 254, 1};
        vec[10] = '{287, 254, 240};
        vec[11] = '{288, 254, 254};

        Srst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk_0);
        chk_reset_values("reset");
        Srst = 1'b0;
        @(negedge clk_0);

        // Full sweep, always ready: applied points, timing and clamping
        epoch++;
        d0 = done_cnt;
        start_sweep();
        chk("busy_after_start", int'(busy), 1);
        chk("en_after_start", int'(EN_REGRAS), 1);
        for (int v = 0; v < 12; v++) begin
            advance_to(PER_PT * vec[v].k + 1);
            chk($sformatf("pt%0d_first_e1", vec[v].k), int'(Entrada_01), vec[v].e1);
            chk($sformatf("pt%0d_first_e2", vec[v].k), int'(Entrada_02), vec[v].e2);
            if (v == 0) begin
                advance_to(PER_PT - 1);
                chk("valid_before_first_push", int'(res_valid), 0);
            end
            advance_to(PER_PT * vec[v].k + PER_PT);
            chk($sformatf("pt%0d_last_e1", vec[v].k), int'(Entrada_01), vec[v].e1);
            chk($sformatf("pt%0d_last_e2", vec[v].k), int'(Entrada_02), vec[v].e2);
            if (v == 0)
                chk("valid_after_first_push", int'(res_valid), 1);
        end
        chk("done_pulse", int'(done), 1);
        advance_to(PER_PT * NPTS + 1);
        chk("busy_after_done", int'(busy), 0);
        chk("en_after_done", int'(EN_REGRAS), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("hold_last_e1", int'(Entrada_01), 254);
        chk("hold_last_e2", int'(Entrada_02), 254);
        drain(100);
        chk("sweep1_done_count", done_cnt - d0, 1);
        chk("sweep1_popped", exp_idx, NPTS);

        // Backpressure: 16 results fill the FIFO, 17th point stalls
        epoch++;
        ready_mode = 2;
        man_ready  = 0;
        d0 = done_cnt;
        start_sweep();
        advance_to(700);
        chk("stall_e1", int'(Entrada_01), 1);
        chk("stall_e2", int'(Entrada_02), 254);
        chk("stall_busy", int'(busy), 1);
        chk("stall_head_idx", int'(res_idx), 0);
        man_ready = 1;
        advance_to(701);
        man_ready = 0;
        chk("unstall_head_idx", int'(res_idx), 1);
        chk("unstall_hold_e2", int'(Entrada_02), 254);
        advance_to(702);
        chk("resume_e1", int'(Entrada_01), 16);
        chk("resume_e2", int'(Entrada_02), 1);
        ready_mode = 1;
        wait_done(12000);
        drain(200);
        chk("sweep2_done_count", done_cnt - d0, 1);
        chk("sweep2_popped", exp_idx, NPTS);

        // Abort during SETTLE of point 100; start while busy ignored
        epoch++;
        ready_mode = 0;
        d0 = done_cnt;
        start_sweep();
        advance_to(1000);
        start = 1'b1;
        advance_to(1001);
        start = 1'b0;
        advance_to(PER_PT * 100 + 5);
        chk("pt100_e1", int'(Entrada_01), pt_e1(100));
        chk("pt100_e2", int'(Entrada_02), pt_e2(100));
        advance_to(PER_PT * 100 + 10);
        abort = 1'b1;
        advance_to(PER_PT * 100 + 11);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_en", int'(EN_REGRAS), 0);
        advance_to(PER_PT * 100 + 200);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_popped", exp_idx, 100);
        chk("abort_fifo_empty", int'(res_valid), 0);

        // start and abort together in IDLE: start wins
        epoch++;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk_0);
        start = 1'b0;
        chk("start_wins_busy", int'(busy), 1);
        @(negedge clk_0);
        abort = 1'b0;
        chk("abort_in_apply_busy", int'(busy), 0);

        // Asynchronous reset between edges, then a full randomized sweep
        epoch++;
        ready_mode = 1;
        start_sweep();
        advance_to(2000 + int'($urandom_range(0, 500)));
        #2;
        Srst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        epoch++;
        @(negedge clk_0);
        Srst = 1'b0;
        @(negedge clk_0);
        d0 = done_cnt;
        start_sweep();
        wait_done(12000);
        drain(200);
        chk("sweep3_done_count", done_cnt - d0, 1);
        chk("sweep3_popped", exp_idx, NPTS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
